// File: rtl/cma_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cma_seq_pkg
// Description : Shared definitions for the CMA job sequencer: default widths
//               aligned with the global CMA constants, the watchdog default,
//               and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cma_seq_pkg;

  localparam int c_DATA_W = 32;     // CMA data word width
  localparam int c_ADR_W  = 16;     // CMA global address width
  localparam int c_LEN_W  = 12;     // load / readback word-count width
  localparam int c_TO_CYC = 65535;  // default watchdog limit in WAIT cycles

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_READ = 3'd4,
    S_RCAP = 3'd5,
    S_OUT  = 3'd6
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/cma_job_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : cma_job_sequencer_if
// Description : Host-side bundle of the job sequencer: descriptor channel
//               (cmd_*), load-word stream (wd_*) and result stream (rd_*).
//               master = host, slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cma_job_sequencer_if #(
  parameter int DATA_W = cma_seq_pkg::c_DATA_W,
  parameter int ADR_W  = cma_seq_pkg::c_ADR_W,
  parameter int LEN_W  = cma_seq_pkg::c_LEN_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADR_W-1:0]  cmd_wbase;
  logic [LEN_W-1:0]  cmd_wlen;
  logic [ADR_W-1:0]  cmd_rbase;
  logic [LEN_W-1:0]  cmd_rlen;
  logic              cmd_bank;
  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output cmd_valid, cmd_wbase, cmd_wlen, cmd_rbase, cmd_rlen, cmd_bank,
    output wd_valid, wd_data, rd_ready,
    input  cmd_ready, wd_ready, rd_valid, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_wbase, cmd_wlen, cmd_rbase, cmd_rlen, cmd_bank,
    input  wd_valid, wd_data, rd_ready,
    output cmd_ready, wd_ready, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/cma_seq_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : cma_seq_addr_gen
// Description : Base + index address generator with last-word compare.
//               start latches base/len and zeroes the index; step advances it.
//               addr wraps modulo 2^ADR_W; last is high while the current
//               index is the final word of the run.
// Ports       : clk, rst   - clock, async active-high reset
//               start      - latch base_in / len_in, index <= 0
//               step       - index++
//               addr, last - current address, final-word flag
// Revision    : 1.0 - initial release
// ============================================================================
module cma_seq_addr_gen
  import cma_seq_pkg::*;
#(
  parameter int ADR_W = c_ADR_W,
  parameter int LEN_W = c_LEN_W
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              start,
  input  wire [ADR_W-1:0]  base_in,
  input  wire [LEN_W-1:0]  len_in,
  input  wire              step,
  output logic [ADR_W-1:0] addr,
  output logic             last
);

  logic [ADR_W-1:0] r_base;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_len  <= '0;
      r_idx  <= '0;
    end else if (start) begin
      r_base <= base_in;
      r_len  <= len_in;
      r_idx  <= '0;
    end else if (step) begin
      r_idx  <= r_idx + 1'b1;
    end
  end

  assign addr = r_base + ADR_W'(r_idx);
  // One extra bit so idx+1 cannot wrap when len is the maximum count.
  assign last = ({1'b0, r_idx} + 1'b1) == {1'b0, r_len};

endmodule
`default_nettype wire

// File: rtl/cma_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cma_job_sequencer
// Description : Sequences one CMA job at a time: stream load words into CMA
//               memory, select bank, pulse run, wait for done under a
//               watchdog, then read result words back one at a time.
// Ports       : clk, rst        - clock, async active-high reset
//               host (slave)    - descriptor / load / result streams
//               o_exwe, o_exre, o_exwd, o_exa, o_cbank, o_run - CMA port
//               i_done, i_exrd  - CMA completion level, read data
//               busy            - not idle
//               timeout_err     - sticky watchdog flag, cleared by next job
// Revision    : 1.0 - initial release
// ============================================================================
module cma_job_sequencer
  import cma_seq_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int ADR_W  = c_ADR_W,
  parameter int LEN_W  = c_LEN_W,
  parameter int RD_LAT = 1,
  parameter int TO_CYC = c_TO_CYC
) (
  input  wire                clk,
  input  wire                rst,
  cma_job_sequencer_if.slave host,
  output logic               o_exwe,
  output logic               o_exre,
  output logic [DATA_W-1:0]  o_exwd,
  output logic [ADR_W-1:0]   o_exa,
  output logic               o_cbank,
  output logic               o_run,
  input  wire                i_done,
  input  wire  [DATA_W-1:0]  i_exrd,
  output logic               busy,
  output logic               timeout_err
);

  localparam int                c_TO_W     = $clog2(TO_CYC + 1);
  localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TO_CYC - 1);
  localparam logic [1:0]        c_LAT_LAST = 2'(RD_LAT - 1);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("cma_job_sequencer: RD_LAT must be 1..4");
  end

  seq_state_t        r_state, w_next;
  logic              r_cbank, r_timeout, r_rlen_nz;
  logic [c_TO_W-1:0] r_wdog;   // index of the current WAIT cycle
  logic [1:0]        r_lat;    // index of the current RCAP cycle
  logic [DATA_W-1:0] r_rd_data;

  logic              w_start, w_wstep, w_rstep, w_exwe, w_exre, w_run;
  logic              w_to_fire, w_capture, w_wlast, w_rlast;
  logic [ADR_W-1:0]  w_waddr, w_raddr;

  cma_seq_addr_gen #(.ADR_W(ADR_W), .LEN_W(LEN_W)) u_wgen (
    .clk(clk), .rst(rst), .start(w_start), .base_in(host.cmd_wbase),
    .len_in(host.cmd_wlen), .step(w_wstep), .addr(w_waddr), .last(w_wlast)
  );

  cma_seq_addr_gen #(.ADR_W(ADR_W), .LEN_W(LEN_W)) u_rgen (
    .clk(clk), .rst(rst), .start(w_start), .base_in(host.cmd_rbase),
    .len_in(host.cmd_rlen), .step(w_rstep), .addr(w_raddr), .last(w_rlast)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cbank   <= 1'b0;
      r_timeout <= 1'b0;
      r_rlen_nz <= 1'b0;
      r_wdog    <= '0;
      r_lat     <= '0;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cbank   <= host.cmd_bank;
        r_timeout <= 1'b0;
        r_rlen_nz <= (host.cmd_rlen != '0);
      end
      if (w_to_fire) r_timeout <= 1'b1;
      if (r_state == S_WAIT) r_wdog <= r_wdog + 1'b1;
      else                   r_wdog <= '0;
      if (r_state == S_RCAP) r_lat <= r_lat + 1'b1;
      else                   r_lat <= '0;
      if (w_capture) r_rd_data <= i_exrd;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_wstep   = 1'b0;
    w_rstep   = 1'b0;
    w_exwe    = 1'b0;
    w_exre    = 1'b0;
    w_run     = 1'b0;
    w_to_fire = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      S_IDLE: if (host.cmd_valid) begin
        w_start = 1'b1;
        w_next  = (host.cmd_wlen != '0) ? S_LOAD : S_RUN;
      end
      S_LOAD: if (host.wd_valid) begin
        w_exwe  = 1'b1;
        w_wstep = 1'b1;
        if (w_wlast) w_next = S_RUN;
      end
      S_RUN: begin
        w_run  = 1'b1;
        w_next = S_WAIT;
      end
      // Done wins over the watchdog on the final WAIT cycle.
      S_WAIT: if (i_done) begin
        w_next = r_rlen_nz ? S_READ : S_IDLE;
      end else if (r_wdog == c_TO_LAST) begin
        w_to_fire = 1'b1;
        w_next    = S_IDLE;
      end
      S_READ: begin
        w_exre = 1'b1;
        w_next = S_RCAP;
      end
      S_RCAP: if (r_lat == c_LAT_LAST) begin
        w_capture = 1'b1;
        w_next    = S_OUT;
      end
      S_OUT: if (host.rd_ready) begin
        w_rstep = 1'b1;
        w_next  = w_rlast ? S_IDLE : S_READ;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign o_exwe      = w_exwe;
  assign o_exre      = w_exre;
  assign o_run       = w_run;
  assign o_exwd      = w_exwe ? host.wd_data : '0;
  assign o_exa       = w_exwe ? w_waddr : (w_exre ? w_raddr : '0);
  assign o_cbank     = r_cbank;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout;

  // Gated with rst so every output reads 0 while reset is held.
  assign host.cmd_ready = (r_state == S_IDLE) && !rst;
  assign host.wd_ready  = (r_state == S_LOAD);
  assign host.rd_valid  = (r_state == S_OUT);
  assign host.rd_data   = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_cma_job_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cma_job_sequencer
// Description : Self-checking bench for cma_job_sequencer. A CMA model
//               supplies i_done and latency-accurate i_exrd; jobs come from a
//               vector table, hand-written reset/watchdog sequences and
//               random descriptors checked against a list-based job model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cma_job_sequencer;

  localparam int DATA_W = 32;
  localparam int ADR_W  = 16;
  localparam int LEN_W  = 12;
  localparam int RD_LAT = 2;
  localparam int TO_CYC = 20;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              o_exwe, o_exre, o_cbank, o_run, busy, timeout_err;
  logic [DATA_W-1:0] o_exwd;
  logic [ADR_W-1:0]  o_exa;
  logic              i_done = 1'b0;
  logic [DATA_W-1:0] i_exrd = '0;

  always #5 clk = ~clk;

  cma_job_sequencer_if #(.DATA_W(DATA_W), .ADR_W(ADR_W), .LEN_W(LEN_W)) host();

  cma_job_sequencer #(
    .DATA_W(DATA_W), .ADR_W(ADR_W), .LEN_W(LEN_W), .RD_LAT(RD_LAT), .TO_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .host(host),
    .o_exwe(o_exwe), .o_exre(o_exre), .o_exwd(o_exwd), .o_exa(o_exa),
    .o_cbank(o_cbank), .o_run(o_run), .i_done(i_done), .i_exrd(i_exrd),
    .busy(busy), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed { logic [15:0] a; logic [31:0] d; } wr_t;

  // ---------------- monitor + CMA model ----------------
  wr_t         wr_log[$];
  logic [15:0] rda_log[$];
  int          run_cnt = 0, cyc = 0, run_cyc = 0;
  int          dcnt = 0, done_after = 0, rd_cd = 0;
  bit          run_flag = 0;
  logic [15:0] rd_pa = '0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      chk("strobe_excl", o_exwe && o_exre, 0);
      chk("exa_idle", (!o_exwe && !o_exre) ? o_exa : 16'h0, 0);
      chk("exwe_hs", o_exwe, host.wd_valid && host.wd_ready);
      if (o_exwe) begin
        chk("exwd", o_exwd, host.wd_data);
        wr_log.push_back({o_exa, o_exwd});
      end
      if (o_exre) begin
        rda_log.push_back(o_exa);
        rd_cd = RD_LAT;
        rd_pa = o_exa;
      end
      if (o_run) begin
        run_cnt++;
        run_flag = 1;
        run_cyc  = cyc;
      end
    end
  end

  // done rises done_after cycles after the run pulse (0 = never);
  // read data is valid only in the cycle RD_LAT after the read strobe.
  always @(posedge clk) begin
    #1;
    if (run_flag) begin dcnt = 1; run_flag = 0; end
    else if (dcnt > 0) dcnt++;
    i_done = (done_after > 0) && (dcnt >= done_after);
    if (rd_cd > 0) begin
      rd_cd--;
      i_exrd = (rd_cd == 0) ? {16'h0, rd_pa ^ 16'hFFFF} : $urandom;
    end else begin
      i_exrd = $urandom;
    end
  end

  // ---------------- one job against the reference model ----------------
  task automatic run_job(input string nm, input logic [15:0] wb, input int wl,
                         input logic [15:0] rb, input int rl, input bit bank,
                         input int dly, input bit gap, input int stall,
                         input logic [31:0] dbase, input bit rnd, input bit exp_to);
    logic [31:0] wdat[$];
    wr_t         exp_w[$];
    logic [15:0] exp_ra[$];
    logic [31:0] got_rd[$];
    logic [31:0] held;
    int          widx, sc, low_cyc;
    bit          holding;
    for (int i = 0; i < wl; i++) begin
      wdat.push_back(rnd ? $urandom : dbase + 32'(i));
      exp_w.push_back({wb + 16'(i), wdat[i]});
    end
    if (!exp_to) for (int i = 0; i < rl; i++) exp_ra.push_back(rb + 16'(i));

    @(posedge clk); #1;
    done_after = dly;
    wr_log.delete(); rda_log.delete(); run_cnt = 0;
    host.cmd_valid = 1; host.cmd_wbase = wb; host.cmd_wlen = LEN_W'(wl);
    host.cmd_rbase = rb; host.cmd_rlen = LEN_W'(rl); host.cmd_bank = bank;
    @(negedge clk); #1;
    chk({nm, " cmd_ready"}, host.cmd_ready, 1);
    widx = 0; sc = 0; holding = 0; low_cyc = -1; held = '0;
    for (int c = 0; c < 30000; c++) begin
      @(posedge clk); #1;
      host.cmd_valid = 0;
      host.wd_valid  = (widx < wl) && (!gap || (c % 2 == 1));
      host.wd_data   = (widx < wl) ? wdat[widx] : 32'h0;
      host.rd_ready  = (sc >= stall);
      @(negedge clk); #1;
      if (host.wd_valid && host.wd_ready) widx++;
      if (host.rd_valid) begin
        if (holding) chk({nm, " rd_stable"}, host.rd_data, held);
        if (host.rd_ready) begin got_rd.push_back(host.rd_data); sc = 0; holding = 0; end
        else begin sc++; holding = 1; held = host.rd_data; end
      end
      if (!busy) begin low_cyc = cyc; break; end
    end
    host.wd_valid = 0; host.rd_ready = 0;

    chk({nm, " completed"}, low_cyc != -1, 1);
    chk({nm, " ready_after"}, host.cmd_ready, 1);
    chk({nm, " nwrites"}, wr_log.size(), exp_w.size());
    for (int i = 0; i < wr_log.size() && i < exp_w.size(); i++)
      chk({nm, " write"}, wr_log[i], exp_w[i]);
    chk({nm, " nreads"}, rda_log.size(), exp_ra.size());
    for (int i = 0; i < rda_log.size() && i < exp_ra.size(); i++)
      chk({nm, " read_addr"}, rda_log[i], exp_ra[i]);
    chk({nm, " nresults"}, got_rd.size(), exp_ra.size());
    for (int i = 0; i < got_rd.size() && i < exp_ra.size(); i++)
      chk({nm, " rd_data"}, got_rd[i], {16'h0, exp_ra[i] ^ 16'hFFFF});
    chk({nm, " run_pulses"}, run_cnt, 1);
    chk({nm, " timeout_err"}, timeout_err, exp_to);
    chk({nm, " cbank"}, o_cbank, bank);
    if ((rl == 0 || exp_to) && low_cyc != -1)
      chk({nm, " idle_latency"}, low_cyc - run_cyc, exp_to ? TO_CYC + 1 : dly + 1);
  endtask

  typedef struct {
    logic [15:0] wb; int wl; logic [15:0] rb; int rl; bit bank;
    int dly; bit gap; int stall; logic [31:0] dbase; bit exp_to;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{16'h0100, 4,    16'h0800, 2,    1'b1, 10, 1'b0, 0, 32'hA0,   1'b0}; // basic
    tbl[1] = '{16'h0200, 6,    16'h0300, 3,    1'b0, 4,  1'b1, 5, 32'h500,  1'b0}; // backpressure
    tbl[2] = '{16'h0000, 0,    16'h0000, 0,    1'b1, 3,  1'b0, 0, 32'h0,    1'b0}; // zero lengths
    tbl[3] = '{16'hFFFE, 4,    16'hFFFF, 2,    1'b0, 1,  1'b0, 0, 32'hC0,   1'b0}; // wrap
    tbl[4] = '{16'h1000, 2,    16'h2000, 3,    1'b1, 0,  1'b0, 0, 32'hD0,   1'b1}; // watchdog
    tbl[5] = '{16'h0000, 0,    16'h3000, 1,    1'b0, 20, 1'b0, 0, 32'h0,    1'b0}; // done on last WAIT
    tbl[6] = '{16'h0000, 1,    16'h4000, 2,    1'b1, 21, 1'b0, 0, 32'hE0,   1'b1}; // done one too late
    tbl[7] = '{16'h0010, 1,    16'h0020, 1,    1'b0, 1,  1'b1, 1, 32'hF0,   1'b0}; // single words
    tbl[8] = '{16'hF800, 4095, 16'h1000, 4095, 1'b1, 2,  1'b0, 0, 32'h1000, 1'b0}; // max length

    host.cmd_valid = 0; host.cmd_wbase = '0; host.cmd_wlen = '0; host.cmd_rbase = '0;
    host.cmd_rlen = '0; host.cmd_bank = 0; host.wd_valid = 0; host.wd_data = '0;
    host.rd_ready = 0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst cmd_ready", host.cmd_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst exa", o_exa, 0);
    chk("rst run", o_run, 0);
    @(negedge clk) rst = 0;
    #1;
    chk("post_rst cmd_ready", host.cmd_ready, 1);
    chk("post_rst cbank", o_cbank, 0);

    foreach (tbl[i])
      run_job($sformatf("vec%0d", i), tbl[i].wb, tbl[i].wl, tbl[i].rb, tbl[i].rl,
              tbl[i].bank, tbl[i].dly, tbl[i].gap, tbl[i].stall, tbl[i].dbase, 1'b0,
              tbl[i].exp_to);

    // random jobs
    for (int j = 0; j < 12; j++) begin
      int dly;
      dly = $urandom_range(0, 24);
      run_job($sformatf("rnd%0d", j), 16'($urandom), $urandom_range(0, 8),
              16'($urandom), $urandom_range(0, 6), 1'($urandom), dly,
              1'($urandom), $urandom_range(0, 3), 32'h0, 1'b1,
              (dly == 0) || (dly > TO_CYC));
    end

    // watchdog flag cleared by reset
    run_job("to_then_rst", 16'h0, 0, 16'h0, 0, 1'b1, 0, 1'b0, 0, 32'h0, 1'b0, 1'b1);
    #2 rst = 1;
    #1;
    chk("rst timeout_err", timeout_err, 0);
    chk("rst cbank_clr", o_cbank, 0);
    @(negedge clk) rst = 0;

    // reset mid-LOAD after the 2nd of 4 words
    @(posedge clk); #1;
    done_after = 5; wr_log.delete();
    host.cmd_valid = 1; host.cmd_wbase = 16'h0040; host.cmd_wlen = 4;
    host.cmd_rbase = 16'h0; host.cmd_rlen = 1; host.cmd_bank = 1;
    @(posedge clk); #1;
    host.cmd_valid = 0; host.wd_valid = 1; host.wd_data = 32'h11;
    @(posedge clk); #1;
    host.wd_data = 32'h22;
    @(posedge clk); #1;
    host.wd_data = 32'h33;
    #1;
    chk("mid_load busy", busy, 1);
    chk("mid_load cbank", o_cbank, 1);
    rst = 1;
    #1;
    chk("mid_rst writes", wr_log.size(), 2);
    chk("mid_rst exwe", o_exwe, 0);
    chk("mid_rst exre", o_exre, 0);
    chk("mid_rst exwd", o_exwd, 0);
    chk("mid_rst exa", o_exa, 0);
    chk("mid_rst run", o_run, 0);
    chk("mid_rst cbank", o_cbank, 0);
    chk("mid_rst busy", busy, 0);
    chk("mid_rst wd_ready", host.wd_ready, 0);
    chk("mid_rst rd_valid", host.rd_valid, 0);
    chk("mid_rst rd_data", host.rd_data, 0);
    chk("mid_rst cmd_ready", host.cmd_ready, 0);
    @(negedge clk) rst = 0;
    host.wd_valid = 0;
    @(negedge clk); #1;
    chk("after_rst cmd_ready", host.cmd_ready, 1);
    chk("after_rst busy", busy, 0);

    run_job("after_rst_job", 16'h0500, 3, 16'h0600, 2, 1'b0, 2, 1'b0, 1, 32'h77, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cma_job_sequencer.md
Name: cma_job_sequencer

Overview:
- Host-side controller that sequences one CMA job at a time through the array's external port.
- Job flow: stream configuration/data words into CMA memory, select the bank, pulse run, wait for done (with a watchdog), then read result words back out.
- Sits between the host command/stream interfaces and the cma external port signals (exwe/exre/exwd/exa/cbank/run/done/exrd).
- Replaces ad-hoc host firmware poking of the external port.

Parameters:
- DATA_W, 32, external data word width (matches the CMA data width).
- ADR_W, 16, CMA global address width.
- LEN_W, 12, word-count width for the load and readback lengths.
- RD_LAT, 1, cycles from o_exre asserted to i_exrd valid; legal range 1..4.
- TO_CYC, 65535, watchdog limit in cycles while waiting for i_done.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cmd_valid  in  1  job descriptor valid.
- cmd_ready  out  1  sequencer accepts a descriptor; high only in IDLE.
- cmd_wbase  in  ADR_W  first load address.
- cmd_wlen  in  LEN_W  number of words to load; 0 skips the load.
- cmd_rbase  in  ADR_W  first readback address.
- cmd_rlen  in  LEN_W  number of words to read back; 0 skips readback.
- cmd_bank  in  1  value driven on o_cbank for this job.
- wd_valid  in  1  load word valid.
- wd_ready  out  1  load word accepted.
- wd_data  in  DATA_W  load word.
- rd_valid  out  1  result word valid.
- rd_ready  in  1  result word consumed.
- rd_data  out  DATA_W  result word.
- o_exwe  out  1  CMA write enable.
- o_exre  out  1  CMA read enable.
- o_exwd  out  DATA_W  CMA write data.
- o_exa  out  ADR_W  CMA address.
- o_cbank  out  1  CMA bank select.
- o_run  out  1  CMA run pulse.
- i_done  in  1  CMA completion, level.
- i_exrd  in  DATA_W  CMA read data.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset: clk and a single asynchronous active-high reset rst; reset is applied immediately, including mid-job. All outputs reset to 0, the FSM goes to IDLE, timeout_err clears, and any in-flight job is abandoned with no completion reported.
- States: IDLE, LOAD, RUN, WAIT, READ, RCAP, OUT.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the descriptor, clear timeout_err, and set o_cbank=cmd_bank, which holds until the next job.
  - Next state: LOAD if wlen≠0, else RUN.
- LOAD:
  - wd_ready=1.
  - On each wd_valid&wd_ready, in the same cycle drive combinationally o_exwe=1, o_exwd=wd_data, o_exa=wbase+idx (mod 2^ADR_W), then idx++.
  - After the wlen-th word, go to RUN.
  - No write occurs without a handshake; stalls are unlimited.
- RUN: o_run=1 for exactly one cycle; next state WAIT with the watchdog counter cleared.
- WAIT:
  - i_done is sampled starting the cycle after o_run; a done level present during the RUN cycle is ignored.
  - i_done=1: go to READ if rlen≠0, else IDLE.
  - Counter reaches TO_CYC without done: set timeout_err=1, skip readback, go to IDLE.
- READ:
  - One cycle with o_exre=1 and o_exa=rbase+ridx (mod 2^ADR_W); next state RCAP.
- RCAP:
  - Wait RD_LAT cycles, then capture i_exrd into rd_data; next state OUT.
- OUT:
  - rd_valid=1 with rd_data stable until rd_ready.
  - On the handshake, ridx++; go to READ if ridx<rlen, else IDLE.
  - Reads are non-pipelined: one outstanding read at a time.
- Strobe exclusivity: o_exwe and o_exre are never high together, and never high outside LOAD and READ respectively.
- Address outputs: o_exa is 0 whenever neither strobe is high.
- Counter widths: idx/ridx are LEN_W wide. The maximum length, 2^LEN_W−1, must work without overflow.
- Back-to-back jobs: a new cmd is accepted in the first IDLE cycle after completion (1 bubble cycle).

Decomposition:
- Shared package cma_seq_pkg holds:
  - FSM state encoding enum.
  - Default widths (DATA_W, ADR_W, LEN_W) aligned with the global CMA width constants.
  - TO_CYC default.
- Sub-module cma_seq_addr_gen: base+index address generator with a length-done compare, instantiated twice (load and readback).

Test Plan:
- Basic job: cmd wbase=0x0100, wlen=4, data 0xA0..0xA3, rbase=0x0800, rlen=2, bank=1; model asserts i_done 10 cycles after run and returns i_exrd=addr^0xFFFF → expect writes at 0x0100..0x0103, exactly one o_run pulse, reads at 0x0800/0x0801, rd_data 0xF7FF then 0xF7FE, o_cbank=1 throughout.
- Backpressure: wd_valid toggles every other cycle and rd_ready is held low 5 cycles per word → no lost or duplicated writes, rd_data stable while stalled.
- Zero lengths: wlen=0, rlen=0 → no exwe/exre activity, a single run pulse, busy drops the cycle after done.
- Address wrap: wbase=0xFFFE, wlen=4 → o_exa sequence FFFE, FFFF, 0000, 0001.
- Watchdog: TO_CYC=20 and i_done never asserted → timeout_err=1 after 20 WAIT cycles, no reads issued, return to IDLE; the next accepted cmd clears timeout_err.
- Reset mid-LOAD: assert rst after the 2nd of 4 words → all outputs 0 with no clock edge, FSM in IDLE, cmd_ready=1 after rst deasserts.
